// File: rtl/sockit_spi_rpo.sv
// SPI master output repackager: splits 32-bit command words into
// lane-interleaved serializer packets of SDW clock periods each.
module sockit_spi_rpo #(
  parameter int SDW = 8,
  parameter int CCI = 6,
  parameter int CDW = 32,
  parameter int QCI = 4,
  parameter int QDW = 4*SDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_vld,
  input  logic [CCI-1:0] cmd_ctl,
  input  logic [CDW-1:0] cmd_dat,
  output logic           cmd_rdy,
  output logic           que_vld,
  output logic [QCI-1:0] que_ctl,
  output logic [QDW-1:0] que_dat,
  input  logic           que_rdy
);

  logic [CDW-1:0] buf_dat_r;
  logic [1:0]     buf_iom_r;
  logic           buf_new_r;
  logic           buf_lst_r;
  logic [1:0]     seg_rem_r;
  logic           seg_fst_r;
  logic           que_vld_r;

  logic           cmd_trn_s;
  logic           que_trn_s;
  logic           seg_lst_s;
  logic [1:0]     eff_cnt_s;
  logic [CDW-1:0] shf_dat_s;

  assign seg_lst_s = (seg_rem_r == 2'd0);
  // Ready follows que_rdy combinationally so a new word can land on the final segment's handshake.
  assign cmd_rdy   = ~que_vld_r | (que_rdy & seg_lst_s);
  assign cmd_trn_s = cmd_vld & cmd_rdy;
  assign que_trn_s = que_vld_r & que_rdy;
  assign que_vld   = que_vld_r;
  assign que_ctl   = {buf_new_r & seg_fst_r, buf_lst_r & seg_lst_s, buf_iom_r};

  // Segment count of an incoming word; wider modes consume more bits per packet.
  always_comb begin
    eff_cnt_s = 2'd0;
    case (cmd_ctl[1:0])
      2'd2:    eff_cnt_s = {1'b0, cmd_ctl[2]};
      2'd3:    eff_cnt_s = 2'd0;
      default: eff_cnt_s = cmd_ctl[3:2];
    endcase
  end

  // Buffer contents after the current segment has been sent.
  always_comb begin
    shf_dat_s = '0;
    case (buf_iom_r)
      2'd2:    shf_dat_s = buf_dat_r << (2*SDW);
      2'd3:    shf_dat_s = '0;
      default: shf_dat_s = buf_dat_r << SDW;
    endcase
  end

  // Lane interleave of the buffer's top bits; the oldest bit goes to the highest active lane.
  always_comb begin
    que_dat = '0;
    case (buf_iom_r)
      2'd2: begin
        for (int i = 0; i < SDW; i++) begin
          que_dat[2*SDW-1-i] = buf_dat_r[CDW-1-2*i];
          que_dat[SDW-1-i]   = buf_dat_r[CDW-2-2*i];
        end
      end
      2'd3: begin
        for (int i = 0; i < SDW; i++) begin
          que_dat[4*SDW-1-i] = buf_dat_r[CDW-1-4*i];
          que_dat[3*SDW-1-i] = buf_dat_r[CDW-2-4*i];
          que_dat[2*SDW-1-i] = buf_dat_r[CDW-3-4*i];
          que_dat[SDW-1-i]   = buf_dat_r[CDW-4-4*i];
        end
      end
      default: begin
        for (int i = 0; i < SDW; i++) begin
          que_dat[SDW-1-i] = buf_dat_r[CDW-1-i];
        end
      end
    endcase
  end

  // Word load, per-segment shift and packet-valid tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_dat_r <= '0;
      buf_iom_r <= 2'd0;
      buf_new_r <= 1'b0;
      buf_lst_r <= 1'b0;
      seg_rem_r <= 2'd0;
      seg_fst_r <= 1'b0;
      que_vld_r <= 1'b0;
    end else if (cmd_trn_s) begin
      buf_dat_r <= cmd_dat;
      buf_iom_r <= cmd_ctl[1:0];
      buf_new_r <= cmd_ctl[5];
      buf_lst_r <= cmd_ctl[4];
      seg_rem_r <= eff_cnt_s;
      seg_fst_r <= 1'b1;
      que_vld_r <= 1'b1;
    end else if (que_trn_s) begin
      if (!seg_lst_s) begin
        buf_dat_r <= shf_dat_s;
        seg_rem_r <= seg_rem_r - 2'd1;
        seg_fst_r <= 1'b0;
      end else begin
        que_vld_r <= 1'b0;
      end
    end else begin
      que_vld_r <= que_vld_r;
    end
  end

endmodule

// File: tb/tb_sockit_spi_rpo.sv
// Self-checking bench for sockit_spi_rpo: directed scenarios plus random traffic
// checked against a packet-list reference model.
module tb_sockit_spi_rpo;

  localparam int SDW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic [5:0]  cmd_ctl = 6'd0;
  logic [31:0] cmd_dat = 32'd0;
  logic        cmd_rdy;
  logic        que_vld;
  logic [3:0]  que_ctl;
  logic [31:0] que_dat;
  logic        que_rdy = 1'b0;

  sockit_spi_rpo #(.SDW(SDW), .CCI(6), .CDW(32), .QCI(4), .QDW(4*SDW)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_ctl(cmd_ctl), .cmd_dat(cmd_dat), .cmd_rdy(cmd_rdy),
    .que_vld(que_vld), .que_ctl(que_ctl), .que_dat(que_dat), .que_rdy(que_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] ctl; logic [31:0] dat; } pkt_t;

  pkt_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic e_vld, e_rdy;
  pkt_t e_pkt;

  // Reference: a word becomes a list of packets; each packet takes the next
  // lanes*SDW bits of the MSB-first stream and deals them round-robin to lanes.
  function automatic void push_word(input logic [5:0] ctl, input logic [31:0] dat);
    int   lanes, bps, nseg, bitpos, lane, pos;
    pkt_t p;
    lanes = (ctl[1:0] == 2'd3) ? 4 : (ctl[1:0] == 2'd2) ? 2 : 1;
    bps   = SDW * lanes;
    nseg  = (ctl[1:0] == 2'd3) ? 1 : (ctl[1:0] == 2'd2) ? int'(ctl[2]) + 1 : int'(ctl[3:2]) + 1;
    for (int k = 0; k < nseg; k++) begin
      p.dat = 32'd0;
      for (int j = 0; j < bps; j++) begin
        bitpos = 31 - (k * bps + j);
        lane   = lanes - 1 - (j % lanes);
        pos    = SDW - 1 - (j / lanes);
        p.dat[lane * SDW + pos] = dat[bitpos];
      end
      p.ctl = {ctl[5] && (k == 0), ctl[4] && (k == nseg - 1), ctl[1:0]};
      exp_q.push_back(p);
    end
  endfunction

  // Apply inputs just after a rising edge, then derive expectations at the falling edge.
  task automatic drive(input logic v, input logic [5:0] c, input logic [31:0] d, input logic r);
    cmd_vld = v; cmd_ctl = c; cmd_dat = d; que_rdy = r;
    @(negedge clk);
    e_vld = (exp_q.size() != 0);
    e_rdy = !e_vld || (que_rdy && exp_q.size() == 1);
    e_pkt = e_vld ? exp_q[0] : '0;
  endtask

  // Advance one clock, updating the model from its own view of the handshakes.
  task automatic tick();
    logic q_t, c_t;
    @(posedge clk);
    q_t = (exp_q.size() != 0) && que_rdy;
    c_t = cmd_vld && ((exp_q.size() == 0) || (que_rdy && exp_q.size() == 1));
    if (q_t) void'(exp_q.pop_front());
    if (c_t) push_word(cmd_ctl, cmd_dat);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({que_vld, cmd_rdy, que_ctl, que_dat} !== {1'b0, 1'b1, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset: got vld=%b rdy=%b ctl=%h dat=%h want 0/1/0/0", que_vld, cmd_rdy, que_ctl, que_dat);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_spi();
    logic [31:0] got = 32'd0;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 6'b111101, 32'hA5C30F81, 1'b1);
      if (que_vld) got = {got[23:0], que_dat[7:0]};
      n_tests++;
      if (que_vld !== e_vld || cmd_rdy !== e_rdy || (e_vld && {que_ctl, que_dat} !== e_pkt)) begin
        n_fail++;
        $display("FAIL spi c%0d: got vld=%b rdy=%b ctl=%h dat=%h want vld=%b rdy=%b pkt=%h", c, que_vld, cmd_rdy, que_ctl, que_dat, e_vld, e_rdy, e_pkt);
      end
      tick();
    end
    n_tests++;
    if (got !== 32'hA5C30F81) begin
      n_fail++;
      $display("FAIL spi_bytes: got %h want a5c30f81", got);
    end
  endtask

  task automatic test_dual();
    logic [31:0] got = 32'd0;
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 6'b110110, 32'hAAAA5555, 1'b1);
      if (que_vld) got = {got[15:0], que_dat[15:0]};
      n_tests++;
      if (que_vld !== e_vld || cmd_rdy !== e_rdy || (e_vld && {que_ctl, que_dat} !== e_pkt)) begin
        n_fail++;
        $display("FAIL dual c%0d: got vld=%b rdy=%b ctl=%h dat=%h want vld=%b rdy=%b pkt=%h", c, que_vld, cmd_rdy, que_ctl, que_dat, e_vld, e_rdy, e_pkt);
      end
      tick();
    end
    n_tests++;
    if (got !== 32'hFF0000FF) begin
      n_fail++;
      $display("FAIL dual_lanes: got %h want ff0000ff", got);
    end
  endtask

  task automatic test_quad_back_to_back();
    int hits = 0;
    for (int c = 0; c < 6; c++) begin
      drive(c < 3, {1'b1, c == 2, 2'b00, 2'b11}, 32'hF000000F, 1'b1);
      if (que_vld && que_dat == 32'h81818181 && c >= 1 && c <= 3) hits++;
      n_tests++;
      if (que_vld !== e_vld || cmd_rdy !== e_rdy || (e_vld && {que_ctl, que_dat} !== e_pkt)) begin
        n_fail++;
        $display("FAIL quad c%0d: got vld=%b rdy=%b ctl=%h dat=%h want vld=%b rdy=%b pkt=%h", c, que_vld, cmd_rdy, que_ctl, que_dat, e_vld, e_rdy, e_pkt);
      end
      tick();
    end
    n_tests++;
    if (hits != 3) begin
      n_fail++;
      $display("FAIL quad_stream: got %0d consecutive 81818181 packets want 3", hits);
    end
  endtask

  task automatic test_partial();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1'b1, 6'b010100, 32'h12345678, 1'b1);
      else        drive(c <= 2, 6'b100001, 32'hDEADBEEF, 1'b1);
      n_tests++;
      if (que_vld !== e_vld || cmd_rdy !== e_rdy || (e_vld && {que_ctl, que_dat} !== e_pkt)) begin
        n_fail++;
        $display("FAIL partial c%0d: got vld=%b rdy=%b ctl=%h dat=%h want vld=%b rdy=%b pkt=%h", c, que_vld, cmd_rdy, que_ctl, que_dat, e_vld, e_rdy, e_pkt);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 11; c++) begin
      if (c == 0) drive(1'b1, 6'b111101, 32'h3C5A9617, 1'b1);
      else        drive(c <= 7, 6'b110001, 32'h0F0F0F0F, !(c >= 2 && c <= 4));
      n_tests++;
      if (que_vld !== e_vld || cmd_rdy !== e_rdy || (e_vld && {que_ctl, que_dat} !== e_pkt)) begin
        n_fail++;
        $display("FAIL backpressure c%0d: got vld=%b rdy=%b ctl=%h dat=%h want vld=%b rdy=%b pkt=%h", c, que_vld, cmd_rdy, que_ctl, que_dat, e_vld, e_rdy, e_pkt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_word();
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, 6'b111101, 32'hC3A5817E, 1'b1);
      tick();
    end
    cmd_vld = 1'b0; que_rdy = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({que_vld, cmd_rdy, que_ctl, que_dat} !== {1'b0, 1'b1, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid: got vld=%b rdy=%b ctl=%h dat=%h want 0/1/0/0", que_vld, cmd_rdy, que_ctl, que_dat);
    end
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 6'b101101, 32'h5A5A5A5A, 1'b1);
      n_tests++;
      if (que_vld !== e_vld || cmd_rdy !== e_rdy || (e_vld && {que_ctl, que_dat} !== e_pkt)) begin
        n_fail++;
        $display("FAIL reset_restart c%0d: got vld=%b rdy=%b ctl=%h dat=%h want vld=%b rdy=%b pkt=%h", c, que_vld, cmd_rdy, que_ctl, que_dat, e_vld, e_rdy, e_pkt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 320; c++) begin
      if (c < 300) drive(($urandom % 3) != 0, 6'($urandom), $urandom, ($urandom % 4) != 0);
      else         drive(1'b0, 6'd0, 32'd0, 1'b1);
      n_tests++;
      if (que_vld !== e_vld || cmd_rdy !== e_rdy || (e_vld && {que_ctl, que_dat} !== e_pkt)) begin
        n_fail++;
        $display("FAIL random c%0d: got vld=%b rdy=%b ctl=%h dat=%h want vld=%b rdy=%b pkt=%h", c, que_vld, cmd_rdy, que_ctl, que_dat, e_vld, e_rdy, e_pkt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_spi();
    test_dual();
    test_quad_back_to_back();
    test_partial();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
